dmem_responder: RTL and testbench

Data-memory responder for the five-stage MIPS CPU: it serves the load/store requests issued by the memory stage over a valid/ready request channel and a single-cycle response strobe. It holds a 128-word data store, applies per-byte write enables, inserts a programmable number of wait states to model slower memory, and reports `busy` so the hazard logic can stall the pipeline. Exactly one transaction is outstanding at a time, and transactions complete in order.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data-memory responder
package dmem_pkg;

  localparam int LAT_W = 4;
  localparam int BE_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word store with per-byte write enables and a registered read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic [BE_W-1:0] we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  localparam int BYTE_W = DW / BE_W;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Contents are deliberately left unreset; the read register only moves on a load.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we[i]) begin
        mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with programmable wait states and busy report
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [BE_W-1:0] req_be,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            busy
);

  localparam bit              ZERO_LAT = (LATENCY == 0);
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  dmem_state_t state_q, state_d;

  logic [LAT_W-1:0] cnt_q;
  logic             lat_wr;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;
  logic [BE_W-1:0]  lat_be;

  logic             accept;
  logic             wait_done;
  logic             mem_go;
  logic             go_wr;
  logic [BE_W-1:0]  go_be;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [BE_W-1:0]  mem_we;
  logic             mem_re;
  logic [DW-1:0]    mem_rdata;

  assign accept    = req_valid & req_ready;
  assign wait_done = (state_q == WAIT) && (cnt_q == '0);

  // With zero latency the access happens on the accepting edge, straight from the inputs.
  always_comb begin
    mem_go    = wait_done;
    go_wr     = lat_wr;
    go_be     = lat_be;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    if (ZERO_LAT && accept) begin
      mem_go    = 1'b1;
      go_wr     = req_wr;
      go_be     = req_be;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
    end
    mem_we = (mem_go && go_wr) ? go_be : '0;
    mem_re = mem_go && !go_wr;
  end

  dmem_array #(
    .AW (AW),
    .DW (DW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ZERO_LAT ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        if (accept) state_d = ZERO_LAT ? RESP : WAIT;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && ((state_q == IDLE) || (state_q == RESP));
    busy      = (state_q == WAIT);
    rsp_valid = (state_q == RESP);
    rsp_rdata = (rsp_valid && !lat_wr) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      if (accept) begin
        cnt_q     <= LAT_LOAD;
        lat_wr    <= req_wr;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench over three latency configurations
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wr    [3];
  logic [6:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        busy      [3];

  logic [31:0] mdl [3][128];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
    dmem_responder #(.AW(7), .DW(32), .LATENCY(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_wr    (req_wr[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_be    (req_be[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .busy      (busy[gi])
    );
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_store(input int k, input logic [6:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++)
      if (be[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
  endtask

  // Issues one request and reports what was observed: cycles from acceptance to the strobe,
  // number of busy cycles in between, and the response data. lat is -1 on a timeout.
  task automatic run_txn(input int k, input logic wr, input logic [6:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rdata, output int lat, output int bcnt);
    int n;
    lat = -1; bcnt = 0; rdata = '0;
    req_valid[k] = 1'b1; req_wr[k] = wr; req_addr[k] = a; req_wdata[k] = d; req_be[k] = be;
    n = 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready[k]) begin req_valid[k] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_addr[k] = ~a; req_wdata[k] = ~d; req_be[k] = 4'($urandom);
    n = 1;
    while (!rsp_valid[k] && n < 40) begin
      if (busy[k]) bcnt++;
      @(posedge clk); #1; n++;
    end
    if (rsp_valid[k]) begin lat = n; rdata = rsp_rdata[k]; end
  endtask

  task automatic test_reset;
    logic [31:0] rd; int lat, bc; logic [31:0] d;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_wr[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
    end
    repeat (3) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++; if (req_ready[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d] got %b exp 0", k, req_ready[k]); end
        checks++; if (rsp_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid[%0d] got %b exp 0", k, rsp_valid[k]); end
        checks++; if (rsp_rdata[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d] got %h exp 0", k, rsp_rdata[k]); end
        checks++; if (busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got %b exp 0", k, busy[k]); end
      end
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready[k] !== 1'b1) begin failures++; $display("FAIL release_ready[%0d] got %b exp 1", k, req_ready[k]); end
    end
    d = $urandom;
    run_txn(1, 1'b1, 7'd0, d, 4'hF, rd, lat, bc);
    model_store(1, 7'd0, d, 4'hF);
    checks++; if (lat !== 3) begin failures++; $display("FAIL first_accept_latency got %0d exp 3", lat); end
  endtask

  task automatic init_all;
    logic [31:0] rd, d; int lat, bc;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 128; a++) begin
        d = $urandom;
        run_txn(k, 1'b1, 7'(a), d, 4'hF, rd, lat, bc);
        model_store(k, 7'(a), d, 4'hF);
        checks++;
        if (lat !== lat_of(k) + 1 || rd !== 32'h0) begin
          failures++; $display("FAIL init_store[%0d][%0d] lat %0d rdata %h exp lat %0d rdata 0", k, a, lat, rd, lat_of(k) + 1);
        end
      end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; int lat, bc;
    run_txn(1, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF, rd, lat, bc);
    model_store(1, 7'd5, 32'hDEADBEEF, 4'hF);
    checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got %0d exp 3", lat); end
    checks++; if (bc !== 2) begin failures++; $display("FAIL store_busy_cycles got %0d exp 2", bc); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL store_rdata got %h exp 0", rd); end
    run_txn(1, 1'b0, 7'd5, $urandom, 4'($urandom), rd, lat, bc);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_after_store got %h exp deadbeef", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got %0d exp 3", lat); end
  endtask

  task automatic test_partial_store;
    logic [31:0] rd; int lat, bc;
    run_txn(1, 1'b1, 7'd9, 32'h11223344, 4'hF, rd, lat, bc);
    model_store(1, 7'd9, 32'h11223344, 4'hF);
    run_txn(1, 1'b1, 7'd9, 32'hAABBCCDD, 4'b0101, rd, lat, bc);
    model_store(1, 7'd9, 32'hAABBCCDD, 4'b0101);
    run_txn(1, 1'b0, 7'd9, '0, '0, rd, lat, bc);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL partial_store got %h exp 11bb33dd", rd); end
    run_txn(1, 1'b1, 7'd9, 32'hFFFFFFFF, 4'h0, rd, lat, bc);
    checks++; if (lat !== 3) begin failures++; $display("FAIL be0_store_latency got %0d exp 3", lat); end
    run_txn(1, 1'b0, 7'd9, '0, '0, rd, lat, bc);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL be0_no_change got %h exp 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int lat, bc;
    for (int a = 0; a < 4; a++) begin
      run_txn(0, 1'b1, 7'(a), 32'h10 + 32'(a), 4'hF, rd, lat, bc);
      model_store(0, 7'(a), 32'h10 + 32'(a), 4'hF);
    end
    req_valid[0] = 1'b1; req_wr[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[0] = 7'(i);
      #0;
      checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready[0]); end
      @(posedge clk); #1;
      checks++; if (rsp_valid[0] !== 1'b1) begin failures++; $display("FAIL b2b_rsp_valid[%0d] got %b exp 1", i, rsp_valid[0]); end
      checks++; if (rsp_rdata[0] !== 32'h10 + 32'(i)) begin failures++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rsp_rdata[0], 32'h10 + 32'(i)); end
      checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL b2b_busy[%0d] got %b exp 0", i, busy[0]); end
    end
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL b2b_idle got %b exp 0", rsp_valid[0]); end
  endtask

  task automatic test_input_change;
    logic [31:0] rd, d; int lat, bc;
    d = $urandom;
    run_txn(2, 1'b1, 7'd20, d, 4'hF, rd, lat, bc);
    model_store(2, 7'd20, d, 4'hF);
    checks++; if (lat !== 4) begin failures++; $display("FAIL latch_store_latency got %0d exp 4", lat); end
    run_txn(2, 1'b0, 7'd20, '0, '0, rd, lat, bc);
    checks++; if (rd !== d) begin failures++; $display("FAIL latch_addr_data got %h exp %h", rd, d); end
    run_txn(2, 1'b0, ~7'd20, '0, '0, rd, lat, bc);
    checks++; if (rd !== mdl[2][~7'd20]) begin failures++; $display("FAIL latch_other_addr got %h exp %h", rd, mdl[2][~7'd20]); end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; int lat, bc, n;
    run_txn(2, 1'b1, 7'd2, 32'h7, 4'hF, rd, lat, bc);
    model_store(2, 7'd2, 32'h7, 4'hF);
    req_valid[2] = 1'b1; req_wr[2] = 1'b1; req_addr[2] = 7'd2; req_wdata[2] = 32'h5; req_be[2] = 4'hF;
    n = 0;
    while (!req_ready[2] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    checks++; if (busy[2] !== 1'b1) begin failures++; $display("FAIL midwait_busy_before_reset got %b exp 1", busy[2]); end
    rst_n[2] = 1'b0;
    #1;
    checks++; if (busy[2] !== 1'b0) begin failures++; $display("FAIL midwait_busy_in_reset got %b exp 0", busy[2]); end
    repeat (2) @(posedge clk);
    #1; rst_n[2] = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid[2]) n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL midwait_no_response got %0d strobes exp 0", n); end
    run_txn(2, 1'b0, 7'd2, '0, '0, rd, lat, bc);
    checks++; if (rd !== 32'h7) begin failures++; $display("FAIL midwait_no_write got %h exp 7", rd); end
  endtask

  task automatic test_random;
    logic [31:0] rd, d, exp; logic [6:0] a; logic [3:0] be; logic wr; int lat, bc, g;
    for (int k = 0; k < 3; k++)
      for (int n = 0; n < 60; n++) begin
        wr = 1'($urandom); a = 7'($urandom_range(0, 127)); d = $urandom; be = 4'($urandom);
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
        exp = wr ? 32'h0 : mdl[k][a];
        run_txn(k, wr, a, d, be, rd, lat, bc);
        if (wr) model_store(k, a, d, be);
        checks++;
        if (rd !== exp || lat !== lat_of(k) + 1 || bc !== lat_of(k)) begin
          failures++;
          $display("FAIL random[%0d][%0d] wr=%b addr=%0d rdata %h lat %0d busy %0d exp rdata %h lat %0d busy %0d",
                   k, n, wr, a, rd, lat, bc, exp, lat_of(k) + 1, lat_of(k));
        end
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    init_all();
    test_store_load();
    test_partial_store();
    test_back_to_back();
    test_input_change();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
